// File: rtl/fp_div_pkg.sv
// Shared encodings, FSM states and IEEE-754 field classification helpers for the iterative divider.
// Helpers take fields zero-extended to 64 bits so that one package serves every format width.
package fp_div_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_DIVIDE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  function automatic logic [63:0] ones(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  function automatic logic is_nan(input logic [63:0] e, input logic [63:0] m, input int ew);
    return (e == ones(ew)) && (m != 64'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] e, input logic [63:0] m, input int ew);
    return (e == ones(ew)) && (m == 64'd0);
  endfunction

  // Subnormals are flushed, so a zero exponent field alone means zero.
  function automatic logic is_zero(input logic [63:0] e);
    return e == 64'd0;
  endfunction

  function automatic logic [63:0] qnan(input int ew, input int mw);
    return (ones(ew) << mw) | (64'd1 << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Rounds a normalised significand (hidden, mantissa, guard) plus sticky and packs it into an IEEE-754 word.
// Applies overflow to inf/max-finite per rounding direction and flushes tiny results to signed zero.
module fp_round_pack
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [MAN_W+1:0]        sig_i,
  input  logic                    sticky_i,
  input  logic [1:0]              rm_i,
  output logic [EXP_W+MAN_W:0]    res_o,
  output logic                    of_o,
  output logic                    uf_o,
  output logic                    nx_o
);

  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EONE = (EXP_W+2)'(1);

  logic                    guard, lsb, inexact, rup, carry, to_inf, zero_sig;
  logic [MAN_W-1:0]        man_r;
  logic signed [EXP_W+1:0] exp_r;

  always_comb begin
    guard    = sig_i[0];
    lsb      = sig_i[1];
    inexact  = guard | sticky_i;
    zero_sig = ~sig_i[MAN_W+1];
    case (rm_i)
      RM_RNE:  rup = guard & (sticky_i | lsb);
      RM_RTZ:  rup = 1'b0;
      RM_RDN:  rup = sign_i & inexact;
      default: rup = ~sign_i & inexact;
    endcase
    // A carry out of the stored mantissa means 1.11..1 rounded to 10.0: mantissa wraps to 0, exponent bumps.
    {carry, man_r} = {1'b0, sig_i[MAN_W:1]} + {{MAN_W{1'b0}}, rup};
    exp_r  = exp_i + $signed({{(EXP_W+1){1'b0}}, carry});
    to_inf = (rm_i == RM_RNE) | ((rm_i == RM_RDN) & sign_i) | ((rm_i == RM_RUP) & ~sign_i);
    of_o   = ~zero_sig & (exp_r >= EMAX);
    uf_o   = ~zero_sig & ~of_o & (exp_r < EONE);
    nx_o   = inexact | of_o | uf_o;
    if (of_o) begin
      res_o = to_inf ? {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                     : {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else if (uf_o || zero_sig) begin
      res_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      res_o = {sign_i, exp_r[EXP_W-1:0], man_r};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Multi-cycle IEEE-754 divider: radix-2 restoring, one quotient bit per cycle, FTZ on inputs and outputs.
// Operands are captured at accept; the result is held in output registers until consumed.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [1:0]           rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] q,
  output logic [4:0]           flags,
  output logic                 busy
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int R  = MAN_W + 3;
  localparam int CW = $clog2(MAN_W + 4);
  localparam logic [CW-1:0]           LAST = CW'(MAN_W + 2);
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EXP_W+1:0] EONE = (EXP_W+2)'(1);
  localparam logic [W-1:0]            QNAN = W'(qnan(EXP_W, MAN_W));

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d, q_q, q_d;
  logic [4:0]              flags_q, flags_d;
  logic [1:0]              rm_q, rm_d;
  logic                    sign_q, sign_d, spec_q, spec_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  logic [R-1:0]            rem_q, rem_d, quo_q, quo_d, rem_sub;
  logic [MAN_W:0]          div_q, div_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sgn, special, ge;
  logic [W-1:0]     spec_res, rp_res;
  logic [4:0]       spec_flg;
  logic             rp_of, rp_uf, rp_nx;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign ma     = a_q[MAN_W-1:0];
  assign mb     = b_q[MAN_W-1:0];
  assign a_nan  = is_nan(64'(ea), 64'(ma), EXP_W);
  assign b_nan  = is_nan(64'(eb), 64'(mb), EXP_W);
  assign a_inf  = is_inf(64'(ea), 64'(ma), EXP_W);
  assign b_inf  = is_inf(64'(eb), 64'(mb), EXP_W);
  assign a_zero = is_zero(64'(ea));
  assign b_zero = is_zero(64'(eb));
  assign sgn    = a_q[W-1] ^ b_q[W-1];

  always_comb begin
    special  = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res         = QNAN;
      spec_flg[FLG_NV] = 1'b1;
    end else if (b_zero && !a_zero && !a_inf) begin
      spec_res         = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flg[FLG_DZ] = 1'b1;
    end else if (a_inf) begin
      spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf || a_zero) begin
      spec_res = {sgn, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Subtract-then-double keeps r < 2d, so the first bit produced is the integer bit of ma/mb.
  always_comb begin
    ge      = rem_q >= {2'b00, div_q};
    rem_sub = ge ? rem_q - {2'b00, div_q} : rem_q;
  end

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .sig_i   (quo_q[R-1:1]),
    .sticky_i(quo_q[0] | (|rem_q)),
    .rm_i    (rm_q),
    .res_o   (rp_res),
    .of_o    (rp_of),
    .uf_o    (rp_uf),
    .nx_o    (rp_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rm_d    = rm_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    spec_d  = spec_q;
    q_d     = q_q;
    flags_d = flags_q;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            rm_d    = rm;
            state_d = S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_d = sgn;
          exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          rem_d  = {2'b00, 1'b1, ma};
          div_d  = {1'b1, mb};
          quo_d  = '0;
          cnt_d  = '0;
          spec_d = special;
          // Specials pass through ROUND untouched so their result lands two edges after accept.
          if (special) begin
            q_d     = spec_res;
            flags_d = spec_flg;
            state_d = S_ROUND;
          end else begin
            state_d = S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_d = rem_sub << 1;
          quo_d = {quo_q[R-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_NORM;
        end
        S_NORM: begin
          if (!quo_q[R-1]) begin
            quo_d = quo_q << 1;
            exp_d = exp_q - EONE;
          end
          state_d = S_ROUND;
        end
        S_ROUND: begin
          if (!spec_q) begin
            q_d             = rp_res;
            flags_d         = '0;
            flags_d[FLG_OF] = rp_of;
            flags_d[FLG_UF] = rp_uf;
            flags_d[FLG_NX] = rp_nx;
          end
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      spec_q  <= 1'b0;
      q_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spec_q  <= spec_d;
      q_q     <= q_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    rm_q   <= rm_d;
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rem_q  <= rem_d;
    div_q  <= div_d;
    quo_q  <= quo_d;
  end

  assign in_ready  = en && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign q         = q_q;
  assign flags     = flags_q;

endmodule
